// File: rtl/aes_core_arbiter_pkg.sv
// Shared AES arbiter definitions: block/key widths, FSM state encoding
// and an index-width helper used by the arbiter and its round-robin picker.
package aes_core_arbiter_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_EXP   = 3'd1,
        KEY_WAIT  = 3'd2,
        BLK_START = 3'd3,
        BLK_WAIT  = 3'd4,
        RSP       = 3'd5
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_core_arbiter_rr.sv
// rr_arbiter: round-robin picker. Ports: i_req (request vector), i_ptr
// (highest-priority index), o_grant (one-hot winner), o_idx (winner index).
module rr_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    // Scan N positions starting at i_ptr, wrapping; first requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = IW'((int'(i_ptr) + i) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES core among NUM_REQ requesters, one op at a
// time. Ports: clk/reset; req_* (per-channel request bundle + valid/ready);
// rsp_* (per-channel valid/ready, shared result block); aes_* (core control,
// key, input block, and done/busy/result from the core).
// Optional macro AES_ARB_KEY_CACHE_EN: skip key expansion when the last
// expanded key context (key_id, aes256) matches the new request.
module aes_core_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int KEY_ID_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*AES_KEY_W-1:0]  req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0]  req_blk,
    input  logic [NUM_REQ*KEY_ID_W-1:0]   req_key_id,
    input  logic [NUM_REQ-1:0]            req_aes256,
    input  logic [NUM_REQ-1:0]            req_decrypt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [AES_BLK_W-1:0]          rsp_blk,
    output logic                          aes_en,
    output logic                          aes_cipher_mode,
    output logic                          aes_decipher_mode,
    output logic                          aes_key_exp_mode,
    output logic                          aes128_mode,
    output logic                          aes256_mode,
    output logic [AES_KEY_W-1:0]          aes_key,
    output logic [AES_BLK_W-1:0]          aes_in_blk,
    input  logic [AES_BLK_W-1:0]          aes_out_blk,
    input  logic                          aes_done,
    input  logic                          aes_op_in_progress
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_e            r_state;
    arb_state_e            w_next;
    logic [IW-1:0]         r_rr_ptr;
    logic [IW-1:0]         r_win;
    logic [IW-1:0]         w_idx;
    logic [NUM_REQ-1:0]    w_grant;
    logic [AES_KEY_W-1:0]  r_key;
    logic [AES_BLK_W-1:0]  r_blk;
    logic [AES_BLK_W-1:0]  r_rsp_blk;
    logic [KEY_ID_W-1:0]   r_key_id;
    logic                  r_aes256;
    logic                  r_decrypt;
    logic                  w_accept;
    logic                  w_need_exp;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_accept = (r_state == IDLE) && (|req_valid) && !reset;

`ifdef AES_ARB_KEY_CACHE_EN
    logic [KEY_ID_W-1:0] r_cached_id;
    logic                r_cached_aes256;
    logic                r_cache_valid;

    // Compare against the winner's live inputs: they are what gets latched.
    assign w_need_exp = !(r_cache_valid
        && (r_cached_id == req_key_id[w_idx*KEY_ID_W +: KEY_ID_W])
        && (r_cached_aes256 == req_aes256[w_idx]));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_valid   <= 1'b0;
            r_cached_id     <= '0;
            r_cached_aes256 <= 1'b0;
        end else if (r_state == KEY_WAIT && aes_done) begin
            r_cache_valid   <= 1'b1;
            r_cached_id     <= r_key_id;
            r_cached_aes256 <= r_aes256;
        end
    end
`else
    logic w_unused_key_id;

    assign w_need_exp      = 1'b1;
    assign w_unused_key_id = ^r_key_id;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_win     <= '0;
            r_key     <= '0;
            r_blk     <= '0;
            r_key_id  <= '0;
            r_aes256  <= 1'b0;
            r_decrypt <= 1'b0;
            r_rsp_blk <= '0;
        end else begin
            if (w_accept) begin
                r_win     <= w_idx;
                r_key     <= req_key[w_idx*AES_KEY_W +: AES_KEY_W];
                r_blk     <= req_blk[w_idx*AES_BLK_W +: AES_BLK_W];
                r_key_id  <= req_key_id[w_idx*KEY_ID_W +: KEY_ID_W];
                r_aes256  <= req_aes256[w_idx];
                r_decrypt <= req_decrypt[w_idx];
            end
            if (r_state == BLK_WAIT && aes_done) r_rsp_blk <= aes_out_blk;
            if (r_state == RSP && rsp_ready[r_win]) begin
                r_rr_ptr <= (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (|req_valid) w_next = w_need_exp ? KEY_EXP : BLK_START;
            KEY_EXP:   if (!aes_op_in_progress) w_next = KEY_WAIT;
            KEY_WAIT:  if (aes_done) w_next = BLK_START;
            BLK_START: if (!aes_op_in_progress) w_next = BLK_WAIT;
            BLK_WAIT:  if (aes_done) w_next = RSP;
            RSP:       if (rsp_ready[r_win]) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready         = '0;
        rsp_valid         = '0;
        aes_en            = 1'b0;
        aes_key_exp_mode  = 1'b0;
        aes_cipher_mode   = 1'b0;
        aes_decipher_mode = 1'b0;
        if (r_state == IDLE && !reset) req_ready = w_grant;
        if (r_state == RSP) rsp_valid[r_win] = 1'b1;
        if (r_state == KEY_EXP || r_state == BLK_START) begin
            aes_en = !aes_op_in_progress;
        end
        if (r_state == KEY_EXP || r_state == KEY_WAIT) aes_key_exp_mode = 1'b1;
        if (r_state == BLK_START || r_state == BLK_WAIT) begin
            aes_cipher_mode   = !r_decrypt;
            aes_decipher_mode = r_decrypt;
        end
    end

    // Key-size modes only mean something while an operation is held.
    assign aes128_mode = (r_state != IDLE) && !r_aes256;
    assign aes256_mode = (r_state != IDLE) && r_aes256;
    assign aes_key     = r_key;
    assign aes_in_blk  = r_blk;
    assign rsp_blk     = r_rsp_blk;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Testbench for aes_core_arbiter: a stand-in AES core, a request driver,
// and a scoreboard monitor checking arbitration order and results.
module tb_aes_core_arbiter;

    localparam int N  = 2;
    localparam int KW = 4;

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid, req_ready, req_aes256, req_decrypt;
    logic [N*256-1:0]   req_key;
    logic [N*128-1:0]   req_blk;
    logic [N*KW-1:0]    req_key_id;
    logic [N-1:0]       rsp_valid, rsp_ready;
    logic [127:0]       rsp_blk;
    logic               aes_en, aes_cipher_mode, aes_decipher_mode;
    logic               aes_key_exp_mode, aes128_mode, aes256_mode;
    logic [255:0]       aes_key;
    logic [127:0]       aes_in_blk, aes_out_blk;
    logic               aes_done, aes_op_in_progress;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NUM_REQ(N), .KEY_ID_W(KW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_blk(req_blk), .req_key_id(req_key_id),
        .req_aes256(req_aes256), .req_decrypt(req_decrypt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_blk(rsp_blk),
        .aes_en(aes_en), .aes_cipher_mode(aes_cipher_mode),
        .aes_decipher_mode(aes_decipher_mode),
        .aes_key_exp_mode(aes_key_exp_mode),
        .aes128_mode(aes128_mode), .aes256_mode(aes256_mode),
        .aes_key(aes_key), .aes_in_blk(aes_in_blk),
        .aes_out_blk(aes_out_blk), .aes_done(aes_done),
        .aes_op_in_progress(aes_op_in_progress)
    );

    // Stand-in cipher: real answers for the two known vectors, otherwise a
    // keyed mix that depends on every field the arbiter must route.
    function automatic logic [127:0] fake_aes(input logic [255:0] k,
            input logic [127:0] b, input logic a256, input logic dec);
        logic [127:0] r;
        if (!dec && !a256 && k[127:0] == K128 && b == PT) return CT128;
        if (!dec && a256 && k == K256 && b == PT) return CT256;
        r = b ^ k[127:0] ^ (a256 ? {k[191:128], k[255:192]} : 128'h0)
              ^ (dec ? {4{32'hc3c3a5a5}} : 128'h0);
        return {r[122:0], r[127:123]} ^ {4{32'h9e3779b9}};
    endfunction

    // ---------------- stand-in AES core ----------------
    logic         c_busy = 1'b0, c_done = 1'b0, c_blk = 1'b0;
    int           c_cnt = 0;
    logic [127:0] c_out = '0, c_res = '0;
    logic         ext_busy = 1'b0;
    int           lat_max = 4;

    always @(posedge clk) begin
        c_done <= 1'b0;
        if (c_busy) begin
            if (c_cnt <= 1) begin
                c_busy <= 1'b0;
                c_done <= 1'b1;
                c_out  <= c_res;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else if (aes_en) begin
            c_busy <= 1'b1;
            c_blk  <= !aes_key_exp_mode;
            c_cnt  <= int'($urandom_range(lat_max, 1));
            c_res  <= aes_key_exp_mode ? ~aes_in_blk
                    : fake_aes(aes_key, aes_in_blk, aes256_mode, aes_decipher_mode);
        end
    end

    assign aes_out_blk        = c_out;
    assign aes_done           = c_done;
    assign aes_op_in_progress = c_busy | ext_busy;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [255:0]  key;
        logic [127:0]  blk;
        logic [KW-1:0] id;
        logic          a256;
        logic          dec;
    } req_t;

    typedef struct {
        int           ch;
        logic [127:0] blk;
        logic         a256;
        logic         dec;
        bit           kx;
    } exp_t;

    req_t rq[N][$];
    exp_t sb[$];
    int   grant_log[$];
    int   kx_log[$];

    int n_vec = 0, n_err = 0, n_rsp = 0;
    logic [127:0] last_blk = '0;

    task automatic chk(input string name, input logic [255:0] got,
            input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int c);
        return N'(1) << c;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    bit            m_busy = 1'b0, cv = 1'b0, hold = 1'b0, rst_d = 1'b0;
    int            m_ptr = 0, kx = 0;
    logic [KW-1:0] cid = '0;
    logic          c256 = 1'b0;
    logic [N-1:0]  hold_v = '0;
    logic [127:0]  hold_blk = '0;

    initial forever begin
        exp_t e;
        int   w;
        bit   need;
        @(negedge clk);
        if (reset) begin
            if (rst_d) begin
                chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
                chk("rst_req_ready", 256'(req_ready), 256'(0));
                chk("rst_aes_en", 256'(aes_en), 256'(0));
            end
            sb.delete();
            m_busy = 0; m_ptr = 0; cv = 0; hold = 0; kx = 0; rst_d = 1;
            continue;
        end
        rst_d = 0;
        if (hold) begin
            chk("hold_valid", 256'(rsp_valid), 256'(hold_v));
            chk("hold_blk", 256'(rsp_blk), 256'(hold_blk));
        end
        hold = 0;
        if (aes_en) begin
            chk("en_while_busy", 256'(aes_op_in_progress), 256'(0));
            if (!m_busy || sb.size() == 0) begin
                chk("en_when_idle", 256'(m_busy), 256'(1));
            end else if (aes_key_exp_mode) begin
                kx++;
                chk("kx_modes", 256'({aes_cipher_mode, aes_decipher_mode}),
                    256'(0));
            end else begin
                e = sb[0];
                chk("blk_modes", 256'({aes_key_exp_mode, aes_cipher_mode,
                    aes_decipher_mode, aes128_mode, aes256_mode}),
                    256'({1'b0, !e.dec, e.dec, !e.a256, e.a256}));
            end
        end
        if (m_busy) begin
            chk("ready_busy", 256'(req_ready), 256'(0));
        end else if (|req_valid) begin
            w = rr_pick(req_valid, m_ptr);
            chk("grant", 256'(req_ready), 256'(oh(w)));
            e.ch   = w;
            e.a256 = req_aes256[w];
            e.dec  = req_decrypt[w];
            e.blk  = fake_aes(req_key[w*256 +: 256], req_blk[w*128 +: 128],
                              e.a256, e.dec);
`ifdef AES_ARB_KEY_CACHE_EN
            need = !(cv && cid == req_key_id[w*KW +: KW] && c256 == e.a256);
            if (need) begin
                cv = 1; cid = req_key_id[w*KW +: KW]; c256 = e.a256;
            end
`else
            need = 1;
`endif
            e.kx = need;
            sb.push_back(e);
            grant_log.push_back(w);
            kx = 0;
            m_busy = 1;
        end else begin
            chk("ready_none", 256'(req_ready), 256'(0));
        end
        if (|rsp_valid) begin
            if (!m_busy || sb.size() == 0) begin
                chk("rsp_unexpected", 256'(rsp_valid), 256'(0));
            end else begin
                e = sb[0];
                chk("rsp_ch", 256'(rsp_valid), 256'(oh(e.ch)));
                chk("rsp_blk", 256'(rsp_blk), 256'(e.blk));
                if (rsp_ready[e.ch]) begin
                    chk("kx_count", 256'(kx), 256'(e.kx ? 1 : 0));
                    kx_log.push_back(kx);
                    last_blk = rsp_blk;
                    n_rsp++;
                    void'(sb.pop_front());
                    m_busy = 0;
                    m_ptr  = (e.ch + 1) % N;
                end else begin
                    hold = 1; hold_v = rsp_valid; hold_blk = rsp_blk;
                end
            end
        end
    end

    // ---------------- driver ----------------
    int rsp_mode = 1;
    bit busy_en  = 1'b0;

    function automatic bit rq_any();
        for (int c = 0; c < N; c++) if (rq[c].size() > 0) return 1;
        return 0;
    endfunction

    task automatic step();
        logic [N-1:0] acc;
        req_t r;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (acc[c]) req_valid[c] = 1'b0;
            if (!req_valid[c] && rq[c].size() > 0 && !reset) begin
                r = rq[c].pop_front();
                req_key[c*256 +: 256] = r.key;
                req_blk[c*128 +: 128] = r.blk;
                req_key_id[c*KW +: KW] = r.id;
                req_aes256[c]  = r.a256;
                req_decrypt[c] = r.dec;
                req_valid[c]   = 1'b1;
            end
        end
        rsp_ready = (rsp_mode == 0) ? '0 : (rsp_mode == 1) ? '1 : N'($urandom);
        ext_busy  = busy_en && ($urandom_range(0, 3) == 0);
    endtask

    task automatic push_req(input int c, input logic [255:0] k,
            input logic [127:0] b, input int id, input bit a, input bit d);
        req_t r;
        r.key = k; r.blk = b; r.id = KW'(id); r.a256 = a; r.dec = d;
        rq[c].push_back(r);
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int t = 0;
        while ((req_valid != 0 || rq_any() || m_busy) && t < budget) begin
            step();
            t++;
        end
        chk(name, 256'(t >= budget), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int saved;
        reset = 1'b1;
        req_valid = '0; req_key = '0; req_blk = '0; req_key_id = '0;
        req_aes256 = '0; req_decrypt = '0; rsp_ready = '0;
        repeat (3) step();
        chk("rst_out_blk", 256'(rsp_blk), 256'(0));
        chk("rst_aes_key", aes_key, 256'(0));
        chk("rst_in_blk", 256'(aes_in_blk), 256'(0));
        chk("rst_modes", 256'({aes_en, aes_cipher_mode, aes_decipher_mode,
            aes_key_exp_mode, aes128_mode, aes256_mode}), 256'(0));
        reset = 1'b0;
        rsp_mode = 1;

        push_req(0, {128'hfeedfacecafebeef0123456789abcdef, K128}, PT, 1, 0, 0);
        wait_idle("kat128_done", 300);
        chk("kat128_blk", 256'(last_blk), 256'(CT128));

        push_req(1, K256, PT, 2, 1, 0);
        wait_idle("kat256_done", 300);
        chk("kat256_blk", 256'(last_blk), 256'(CT256));

        grant_log.delete();
        for (int i = 0; i < 2; i++) begin
            push_req(0, rnd256(), rnd256()[127:0], 1, 0, 1);
            push_req(1, rnd256(), rnd256()[127:0], 2, 1, 0);
        end
        wait_idle("rr_done", 600);
        chk("rr_count", 256'(grant_log.size()), 256'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            chk("rr_order", 256'(grant_log[i]), 256'(i % 2));
        end

        kx_log.delete();
        push_req(0, rnd256(), rnd256()[127:0], 3, 0, 0);
        push_req(0, rnd256(), rnd256()[127:0], 3, 0, 1);
        push_req(0, rnd256(), rnd256()[127:0], 4, 0, 0);
        wait_idle("cache_done", 600);
        chk("cache_count", 256'(kx_log.size()), 256'(3));
        if (kx_log.size() == 3) begin
            chk("cache_kx0", 256'(kx_log[0]), 256'(1));
`ifdef AES_ARB_KEY_CACHE_EN
            chk("cache_kx1", 256'(kx_log[1]), 256'(0));
`else
            chk("cache_kx1", 256'(kx_log[1]), 256'(1));
`endif
            chk("cache_kx2", 256'(kx_log[2]), 256'(1));
        end

        rsp_mode = 0;
        push_req(0, rnd256(), rnd256()[127:0], 7, 1, 1);
        t = 0;
        while (rsp_valid == 0 && t < 300) begin
            step();
            t++;
        end
        chk("hold_reach", 256'(rsp_valid != 0), 256'(1));
        for (int i = 0; i < 10; i++) begin
            if (i == 2) req_valid[1] = 1'b1;
            if (i == 5) req_valid[1] = 1'b0;
            step();
            chk("hold_req_ready", 256'(req_ready), 256'(0));
        end
        rsp_mode = 1;
        wait_idle("hold_done", 300);

        lat_max = 20;
        saved = n_rsp;
        push_req(1, rnd256(), rnd256()[127:0], 5, 1, 1);
        t = 0;
        while (!(c_busy && c_blk) && t < 300) begin
            step();
            t++;
        end
        chk("abort_reach", 256'(c_busy && c_blk), 256'(1));
        step();
        reset = 1'b1;
        req_valid = '0;
        for (int c = 0; c < N; c++) rq[c].delete();
        step();
        step();
        reset = 1'b0;
        chk("abort_no_rsp", 256'(n_rsp), 256'(saved));
        lat_max = 4;
        push_req(0, {128'h0, K128}, PT, 9, 0, 0);
        wait_idle("abort_next_done", 500);
        chk("abort_next_n", 256'(n_rsp), 256'(saved + 1));
        chk("abort_next_blk", 256'(last_blk), 256'(CT128));

        busy_en  = 1'b1;
        rsp_mode = 2;
        saved = n_rsp;
        for (int i = 0; i < 40; i++) begin
            push_req(int'($urandom_range(0, N - 1)), rnd256(), rnd256()[127:0],
                     int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
        wait_idle("rand_done", 8000);
        chk("rand_n", 256'(n_rsp), 256'(saved + 40));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
